// File: rtl/bcd_scan_if.sv
// rtl/bcd_scan_if.sv - control and display bundle for bcd_scan_counter
interface bcd_scan_if #(
  parameter int DIGITS = 4
);
  logic                run;
  logic                down;
  logic                clear;
  logic [4*DIGITS-1:0] count;
  logic                tick;
  logic                wrap;
  logic [6:0]          seg;
  logic [DIGITS-1:0]   digit_sel;

  modport master (
    output run, down, clear,
    input  count, tick, wrap, seg, digit_sel
  );

  modport slave (
    input  run, down, clear,
    output count, tick, wrap, seg, digit_sel
  );
endinterface

// File: rtl/bcd_scan_counter.sv
// rtl/bcd_scan_counter.sv - prescaled multi-digit BCD up/down counter with 7-seg scan
module bcd_scan_counter #(
  parameter int PRESCALE = 1000,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 8
) (
  input logic       clk,
  input logic       reset,
  bcd_scan_if.slave bus
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  logic [PW-1:0]       pre_q, pre_d;
  logic [4*DIGITS-1:0] count_q, count_d, stepped;
  logic                tick_q, tick_d, wrap_q, wrap_d, ripple;
  logic [SW-1:0]       scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic [6:0]          seg_q, seg_d;
  logic [3:0]          scan_digit;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Ripple carry/borrow through the digits; a ripple out of the top digit is a wrap.
  always_comb begin
    stepped = count_q;
    ripple  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (ripple) begin
        if (!bus.down) begin
          if (count_q[4*i +: 4] == 4'd9) begin
            stepped[4*i +: 4] = 4'd0;
          end else begin
            stepped[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
            ripple = 1'b0;
          end
        end else begin
          if (count_q[4*i +: 4] == 4'd0) begin
            stepped[4*i +: 4] = 4'd9;
          end else begin
            stepped[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
            ripple = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    pre_d   = pre_q;
    count_d = count_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (bus.clear) begin
      pre_d   = '0;
      count_d = '0;
    end else if (bus.run) begin
      if (pre_q == PRE_LAST) begin
        pre_d   = '0;
        count_d = stepped;
        tick_d  = 1'b1;
        wrap_d  = ripple;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  // Scan is free-running; select and segments are produced from the same next index.
  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    sel_d        = '0;
    sel_d[idx_d] = 1'b1;
    scan_digit   = count_q[4*idx_d +: 4];
    seg_d        = seg_decode(scan_digit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q      <= '0;
      count_q    <= '0;
      tick_q     <= 1'b0;
      wrap_q     <= 1'b0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      sel_q      <= DIGITS'(1);
      seg_q      <= 7'h3F;
    end else begin
      pre_q      <= pre_d;
      count_q    <= count_d;
      tick_q     <= tick_d;
      wrap_q     <= wrap_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      sel_q      <= sel_d;
      seg_q      <= seg_d;
    end
  end

  assign bus.count     = count_q;
  assign bus.tick      = tick_q;
  assign bus.wrap      = wrap_q;
  assign bus.seg       = seg_q;
  assign bus.digit_sel = sel_q;
endmodule

// File: tb/tb_bcd_scan_counter.sv
// tb/tb_bcd_scan_counter.sv - scoreboard bench for bcd_scan_counter (PRESCALE=4, DIGITS=2, SCAN_DIV=2)
module tb_bcd_scan_counter;
  localparam int PRESCALE = 4;
  localparam int DIGITS   = 2;
  localparam int SCAN_DIV = 2;

  logic clk = 1'b0;
  logic reset;

  bcd_scan_if #(.DIGITS(DIGITS)) bus ();

  bcd_scan_counter #(
    .PRESCALE(PRESCALE),
    .DIGITS  (DIGITS),
    .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         edge_no;
    logic [7:0] count;
    logic       wrap;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   edge_n = 0;
  int   m_pre = 0;
  int   m_val = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Drive one cycle of inputs, then advance the decimal reference model.
  task automatic step(input logic r, input logic d, input logic c, input logic rs);
    logic w;
    bus.run   = r;
    bus.down  = d;
    bus.clear = c;
    reset     = rs;
    @(posedge clk);
    #1;
    if (rs || c) begin
      m_pre = 0;
      if (rs || c) m_val = 0;
    end else if (r) begin
      if (m_pre == PRESCALE - 1) begin
        m_pre = 0;
        w     = d ? (m_val == 0) : (m_val == 99);
        m_val = d ? (m_val + 99) % 100 : (m_val + 1) % 100;
        sb.push_back('{edge_n, to_bcd(m_val), w});
      end else begin
        m_pre++;
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.tick) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_tick: tick at edge %0d with count %0h, none expected", edge_n, bus.count);
      end else begin
        e = sb.pop_front();
        check("tick_edge", edge_n, e.edge_no);
        check("tick_count", {24'd0, bus.count}, {24'd0, e.count});
        check("tick_wrap", {31'd0, bus.wrap}, {31'd0, e.wrap});
      end
    end else if (bus.wrap) begin
      total++;
      bad++;
      $display("FAIL wrap_without_tick: wrap=1 tick=0 at edge %0d, required wrap=0", edge_n);
    end
    if (sb.size() > 0 && edge_n > sb[0].edge_no) begin
      total++;
      bad++;
      $display("FAIL missing_tick: no tick at edge %0d, required count %0h", sb[0].edge_no, sb[0].count);
      void'(sb.pop_front());
    end
  end

  initial begin
    int p;
    int got;
    logic [1:0] prev_sel;
    int runlen;
    logic seen_change;

    bus.run = 1'b0; bus.down = 1'b0; bus.clear = 1'b0; reset = 1'b1;

    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check("reset_count", {24'd0, bus.count}, 32'h00);
    check("reset_tick", {31'd0, bus.tick}, 32'd0);
    check("reset_wrap", {31'd0, bus.wrap}, 32'd0);
    check("reset_digit_sel", {30'd0, bus.digit_sel}, 32'h1);
    check("reset_seg", {25'd0, bus.seg}, 32'h3F);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0);
    check("idle_hold_count", {24'd0, bus.count}, 32'h00);

    for (int i = 1; i <= 403; i++) begin
      step(1, i > 400, 0, 0);
      if (i == 3)   check("up_pre_tick", {31'd0, bus.tick}, 32'd0);
      if (i == 4)   check("up_first_count", {24'd0, bus.count}, 32'h01);
      if (i == 4)   check("up_first_tick", {31'd0, bus.tick}, 32'd1);
      if (i == 40)  check("up_count_10", {24'd0, bus.count}, 32'h10);
      if (i == 396) check("up_count_99", {24'd0, bus.count}, 32'h99);
      if (i == 400) check("up_wrap_count", {24'd0, bus.count}, 32'h00);
      if (i == 400) check("up_wrap_pulse", {31'd0, bus.wrap}, 32'd1);
      if (i == 401) check("up_wrap_gone", {31'd0, bus.wrap}, 32'd0);
    end

    step(1, 1, 0, 0);
    check("down_wrap_count", {24'd0, bus.count}, 32'h99);
    check("down_wrap_pulse", {31'd0, bus.wrap}, 32'd1);
    for (int j = 1; j <= 8; j++) begin
      step(1, 1, 0, 0);
      if (j == 4) check("down_98", {24'd0, bus.count}, 32'h98);
      if (j == 8) check("down_97", {24'd0, bus.count}, 32'h97);
    end
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    check("dir_toggle_hold", {24'd0, bus.count}, 32'h97);
    step(1, 0, 0, 0);
    check("dir_change_up", {24'd0, bus.count}, 32'h98);
    for (int j = 1; j <= 8; j++) step(1, 0, 0, 0);
    check("up_again_00", {24'd0, bus.count}, 32'h00);

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    p = edge_n;
    for (int k = 0; k < 10; k++) step(0, 0, 0, 0);
    got = -1;
    for (int k = 0; k < 20; k++) begin
      step(1, 0, 0, 0);
      if (bus.tick) begin
        got = edge_n;
        break;
      end
    end
    check("pause_tick_edge", got, p + 12);
    check("pause_count", {24'd0, bus.count}, 32'h01);

    for (int k = 0; k < 3; k++) step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    check("clear_no_tick", {31'd0, bus.tick}, 32'd0);
    check("clear_count", {24'd0, bus.count}, 32'h00);

    for (int k = 0; k < 168; k++) step(1, 0, 0, 0);
    check("scan_count_42", {24'd0, bus.count}, 32'h42);
    step(0, 0, 0, 0);
    prev_sel = bus.digit_sel;
    runlen = 1;
    seen_change = 1'b0;
    for (int s = 0; s < 12; s++) begin
      step(0, 0, s == 5, 0);
      check("scan_onehot", {31'd0, (bus.digit_sel == 2'b01) || (bus.digit_sel == 2'b10)}, 32'd1);
      if (s < 5)
        check("scan_seg_42", {25'd0, bus.seg}, (bus.digit_sel == 2'b01) ? 32'h5B : 32'h66);
      else if (s > 5)
        check("scan_seg_cleared", {25'd0, bus.seg}, 32'h3F);
      if (bus.digit_sel != prev_sel) begin
        if (seen_change) check("scan_cadence", runlen, 2);
        seen_change = 1'b1;
        runlen = 1;
      end else begin
        runlen++;
      end
      prev_sel = bus.digit_sel;
    end

    for (int k = 0; k < 7; k++) step(1, 0, 0, 0);
    check("pre_reset_count", {24'd0, bus.count}, 32'h01);
    step(1, 0, 0, 1);
    check("midreset_count", {24'd0, bus.count}, 32'h00);
    check("midreset_tick", {31'd0, bus.tick}, 32'd0);
    check("midreset_sel", {30'd0, bus.digit_sel}, 32'h1);
    check("midreset_seg", {25'd0, bus.seg}, 32'h3F);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bcd_scan_counter.md
# bcd_scan_counter

Parametrised multi-digit BCD event/seconds counter with on-board seven-segment scan driver. A prescaler divides `clk` into a count tick, and `DIGITS` cascaded BCD digits count up or down on each tick, with pause and clear controls. The digits are time-multiplexed onto a single seven-segment bus with a one-hot digit select. It supersedes the single-digit 0–9 seconds display in the I/O-pin-limited design tiles and drives multi-digit displays from one 7-bit segment bus.

## Interface
- `PRESCALE`, default 1000: `clk` cycles per count tick; must be at least 2. The prescaler is `$clog2(PRESCALE)` bits wide.
- `DIGITS`, default 4: number of BCD digits; must be at least 1.
- `SCAN_DIV`, default 8: `clk` cycles each digit is displayed before the scan advances; must be at least 1.

Ports:
- `clk`  in  1: clock; all logic is on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `run`  in  1: 1 = prescaler advances; 0 = prescaler and digits hold (pause, not reset).
- `down`  in  1: 0 = count up, 1 = count down; sampled on the tick edge only.
- `clear`  in  1: synchronous clear of the digits and prescaler; the scan logic is not affected.
- `count`  out  4*DIGITS: packed BCD; digit 0 is in `[3:0]` and is the least significant.
- `tick`  out  1: one-cycle pulse, asserted with each count update.
- `wrap`  out  1: one-cycle pulse when the full count rolls over.
- `seg`  out  7: active-high segments of the digit currently scanned; bit0 = a … bit6 = g.
- `digit_sel`  out  DIGITS: one-hot, active-high select for the scanned digit.

## Operation
**Priority:** `reset` > `clear` > normal operation.

**Reset values (registered outputs):**
- `count` = 0, `tick` = 0, `wrap` = 0.
- Prescaler = 0, scan index = 0, scan counter = 0.
- `digit_sel` = 1 (digit 0), `seg` = 7'h3F (glyph "0").

**Clear:** prescaler = 0, `count` = 0, `tick` = 0, `wrap` = 0. A tick that would occur in the same cycle is suppressed.

**Prescaler:**
- When `run` = 1, it counts 0 … `PRESCALE`−1.
- On the edge where it equals `PRESCALE`−1, it returns to 0, `tick` is registered 1, and the count is updated on that same edge.
- When `run` = 0, it holds its value and `tick` = 0.

**Up count (on tick):**
- Digit 0 increments; a digit at 9 goes to 0 and carries into the next digit.
- All digits at 9 → all digits 0, and `wrap` = 1 for that cycle.

**Down count (on tick):**
- Digit 0 decrements; a digit at 0 goes to 9 and borrows from the next digit.
- All digits at 0 → all digits 9, and `wrap` = 1.

**Direction change:** toggling `down` between ticks takes effect on the next tick only. No count change ever occurs without a tick.

**Scan:**
- The free-running scan counter runs 0 … `SCAN_DIV`−1, independent of `run` and `clear`.
- On its wrap, the scan index advances (`DIGITS`−1 wraps to 0).
- `digit_sel` is one-hot at the scan index.
- `seg` is the decode of the `count` digit at the scan index.

**Segment encoding:**
- 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F.
- Non-BCD values are unreachable; decode them to 00.

## Timing
- **First tick:** with `run` high from reset release, the first tick and `count` = 1 are visible after the `PRESCALE`-th rising edge. Ticks are then exactly `PRESCALE` cycles apart.
- **`tick`, `wrap`, `count`:** `tick` and `wrap` are high for exactly one cycle, coincident with the new `count` value.
- **Scan registers:** `seg` and `digit_sel` are registered and update on the same edge, so they are never mismatched.
- **Seg latency:** `seg` reflects a `count` change no later than 1 cycle after `count` updates, provided that digit is being scanned.
- **Pause/resume:** a `run` low of N cycles delays the next tick by exactly N cycles. The prescaler phase is preserved.
- **Reset mid-operation:** all state returns to the reset values on the next edge. No `tick` or `wrap` pulse is emitted.

## Test plan
Configuration for all scenarios: `PRESCALE` = 4, `DIGITS` = 2, `SCAN_DIV` = 2.

1. **Reset:** assert `reset` for 2 cycles, then release with `run` = 0 → `count` = 00, `tick` = `wrap` = 0, `digit_sel` = 01, `seg` = 3F; `count` holds at 00 for 20 cycles.
2. **Up count:** `run` = 1, `down` = 0 → `tick` on edges 4, 8, 12, …; `count` = 01 after edge 4; `count` = 10 after edge 40; no `wrap`.
3. **Up wrap:** from 99 → next tick gives `count` = 00 with `wrap` = 1 for one cycle; `wrap` = 0 on all other ticks over 400 cycles.
4. **Down wrap:** from 00 with `down` = 1 → next tick gives 99 with `wrap` = 1; then 98, 97; toggling `down` mid-interval → the direction changes at the following tick only.
5. **Pause and clear:**
   - Drop `run` for 10 cycles after prescaler = 2 → the next tick arrives 12 cycles after that point.
   - Assert `clear` on a tick edge → `count` = 00, no `tick` pulse.
6. **Scan:** force `count` = 42 → `digit_sel` alternates 01 ↔ 10 every 2 cycles, with `seg` = 5B when `digit_sel` = 01 and `seg` = 66 when `digit_sel` = 10. Asserting `clear` does not disturb the scan cadence.
